// File: rtl/led_fade_driver.sv
// led_fade_driver: output stage for the eight general-purpose LED pins.
// The requested pattern is synchronised into pl_clk; every channel then
// ramps its brightness level toward full-on or full-off once per fade tick,
// and a shared free-running PWM counter turns each level into a registered
// drive bit. settled reports that every channel has reached its extreme.
// Optional build macro: LED_FADE_GAMMA_EN (square-law duty mapping with one
// extra registered pipeline stage between level and led_out).
module led_fade_driver #(
    parameter int unsigned NUM_LED  = 8,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned FADE_DIV = 390625,
    parameter int unsigned STEP     = 1
) (
    input  logic               pl_clk,
    input  logic               pl_resetn,
    input  logic [NUM_LED-1:0] led_in,
    output logic [NUM_LED-1:0] led_out,
    output logic               settled
);

    localparam int unsigned         LW       = PWM_BITS + 1;
    localparam int unsigned         DIV_W    = $clog2(FADE_DIV);
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [LW-1:0]       STEP_W   = LW'(STEP);
    localparam logic [PWM_BITS-1:0] STEP_N   = PWM_BITS'(STEP);

    logic [NUM_LED-1:0]  sync1;
    logic [NUM_LED-1:0]  target;
    logic [DIV_W-1:0]    pre_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level     [NUM_LED];
    logic [PWM_BITS-1:0] level_nxt [NUM_LED];
    logic [LW-1:0]       lvl_up    [NUM_LED];
    logic [PWM_BITS-1:0] duty      [NUM_LED];
    logic                all_match;

    // two-flop synchroniser; the second stage is the per-channel target
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            sync1  <= '0;
            target <= '0;
        end else begin
            sync1  <= led_in;
            target <= sync1;
        end
    end

    // fade prescaler: counts 0..FADE_DIV-1 and wraps
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + DIV_W'(1);
        end
    end

    // one-cycle fade tick on the last prescaler count
    always_comb begin
        tick = (pre_cnt == DIV_LAST);
    end

    // saturating level step toward the current target, only on tick
    always_comb begin
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            lvl_up[i]    = {1'b0, level[i]} + STEP_W;
            level_nxt[i] = level[i];
            if (tick) begin
                if (target[i]) begin
                    if (lvl_up[i] > {1'b0, MAX}) begin
                        level_nxt[i] = MAX;
                    end else begin
                        level_nxt[i] = lvl_up[i][PWM_BITS-1:0];
                    end
                end else begin
                    if ({1'b0, level[i]} < STEP_W) begin
                        level_nxt[i] = '0;
                    end else begin
                        level_nxt[i] = level[i] - STEP_N;
                    end
                end
            end
        end
    end

    // brightness level registers
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            for (int unsigned i = 0; i < NUM_LED; i++) begin
                level[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_LED; i++) begin
                level[i] <= level_nxt[i];
            end
        end
    end

    // shared free-running PWM counter, wraps MAX -> 0
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq [NUM_LED];

    // full-width square of each level
    always_comb begin
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            level_sq[i] = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
        end
    end

    // registered gamma duty; full scale is forced so MAX stays fully on
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            for (int unsigned i = 0; i < NUM_LED; i++) begin
                duty[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_LED; i++) begin
                duty[i] <= (level[i] == MAX) ? MAX : PWM_BITS'(level_sq[i] >> PWM_BITS);
            end
        end
    end
`else
    // duty follows the level directly
    always_comb begin
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            duty[i] = level[i];
        end
    end
`endif

    // registered PWM compare; MAX is forced on so full brightness never blinks
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            led_out <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LED; i++) begin
                led_out[i] <= (duty[i] == MAX) || (duty[i] > pwm_cnt);
            end
        end
    end

    // every channel sits at the extreme its target asks for
    always_comb begin
        all_match = 1'b1;
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            if (level[i] != (target[i] ? MAX : '0)) begin
                all_match = 1'b0;
            end
        end
    end

    // registered settled flag
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            settled <= 1'b1;
        end else begin
            settled <= all_match;
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver with FADE_DIV=4, STEP=64,
// PWM_BITS=8, plus a slow-fade instance for duty-cycle measurement.
module tb_led_fade_driver;

    localparam int NL       = 8;
    localparam int FD       = 4;
    localparam int ST       = 64;
    localparam int MAXV     = 255;
    localparam int PERIOD   = 256;
    localparam int SLOW_DIV = 1024;
`ifdef LED_FADE_GAMMA_EN
    localparam bit GAMMA = 1'b1;
`else
    localparam bit GAMMA = 1'b0;
`endif

    logic       pl_clk    = 1'b0;
    logic       pl_resetn = 1'b1;
    logic [7:0] led_in    = '0;
    logic [7:0] led_out;
    logic       settled;

    logic       slow_rstn = 1'b0;
    logic [7:0] slow_in   = '0;
    logic [7:0] slow_out;
    logic       slow_settled;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pl_clk = ~pl_clk;

    led_fade_driver #(.NUM_LED(8), .PWM_BITS(8), .FADE_DIV(FD), .STEP(ST)) dut (
        .pl_clk(pl_clk), .pl_resetn(pl_resetn), .led_in(led_in),
        .led_out(led_out), .settled(settled)
    );

    led_fade_driver #(.NUM_LED(8), .PWM_BITS(8), .FADE_DIV(SLOW_DIV), .STEP(ST)) u_slow (
        .pl_clk(pl_clk), .pl_resetn(slow_rstn), .led_in(slow_in),
        .led_out(slow_out), .settled(slow_settled)
    );

    // Reference model: m_cyc counts rising edges since reset release, so the
    // PWM phase is m_cyc mod 256 and a fade tick happens when m_cyc mod FD
    // is FD-1. Levels move by STEP with clamping at 0 and MAXV.
    int         m_cyc;
    logic [7:0] m_s1, m_tgt, m_out;
    logic       m_set;
    int         m_lvl  [NL];
    int         m_duty [NL];
    logic [63:0] obs_lvl, exp_lvl;

    always @(posedge pl_clk or negedge pl_resetn) begin
        logic [7:0] n_out;
        logic       n_set;
        int         d;
        if (!pl_resetn) begin
            m_cyc = 0; m_s1 = '0; m_tgt = '0; m_out = '0; m_set = 1'b1;
            for (int i = 0; i < NL; i++) begin
                m_lvl[i] = 0; m_duty[i] = 0;
            end
        end else begin
            n_set = 1'b1;
            for (int i = 0; i < NL; i++) begin
                d = GAMMA ? m_duty[i] : m_lvl[i];
                n_out[i] = (d == MAXV) || (d > (m_cyc % PERIOD));
                if (m_lvl[i] != (m_tgt[i] ? MAXV : 0)) n_set = 1'b0;
            end
            for (int i = 0; i < NL; i++)
                m_duty[i] = (m_lvl[i] == MAXV) ? MAXV : (m_lvl[i] * m_lvl[i]) / PERIOD;
            if (m_cyc % FD == FD - 1) begin
                for (int i = 0; i < NL; i++) begin
                    if (m_tgt[i]) m_lvl[i] = (m_lvl[i] + ST > MAXV) ? MAXV : m_lvl[i] + ST;
                    else          m_lvl[i] = (m_lvl[i] - ST < 0) ? 0 : m_lvl[i] - ST;
                end
            end
            m_tgt = m_s1;
            m_s1  = led_in;
            m_cyc++;
            m_out = n_out;
            m_set = n_set;
        end
    end

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            obs_lvl[i*8 +: 8] = dut.level[i];
            exp_lvl[i*8 +: 8] = 8'(m_lvl[i]);
        end
    end

    task automatic test_reset();
        led_in = '0;
        #13 pl_resetn = 1'b0;
        #1;
        n_cmp++;
        if (led_out !== 8'h00 || settled !== 1'b1 || obs_lvl !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_async got out=%h settled=%b lvl=%h exp out=00 settled=1 lvl=0",
                     led_out, settled, obs_lvl);
        end
        @(negedge pl_clk);
        pl_resetn = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if (led_out !== 8'h00 || settled !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got out=%h settled=%b exp out=00 settled=1",
                         c, led_out, settled);
            end
        end
    endtask

    task automatic test_ramp_up();
        int seen[$];
        int want[4];
        int prev;
        bit dropped;
        want = '{64, 128, 192, 255};
        prev = 0;
        dropped = 1'b0;
        led_in = 8'h01;
        for (int c = 0; c < 40; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL ramp_cycle t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
            if (settled === 1'b0) dropped = 1'b1;
            if (int'(dut.level[0]) != prev) begin
                prev = int'(dut.level[0]);
                seen.push_back(prev);
            end
        end
        n_cmp++;
        if (!dropped) begin
            n_bad++;
            $display("FAIL ramp_settled_drop got settled never low exp low during ramp");
        end
        n_cmp++;
        if (seen.size() != 4) begin
            n_bad++;
            $display("FAIL ramp_step_count got %0d exp 4", seen.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (seen[k] != want[k]) begin
                    n_bad++;
                    $display("FAIL ramp_step%0d got %0d exp %0d", k, seen[k], want[k]);
                end
            end
        end
        n_cmp++;
        if (settled !== 1'b1) begin
            n_bad++;
            $display("FAIL ramp_settled_rise got %b exp 1", settled);
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if (led_out[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL ramp_full_on cyc=%0d got %b exp 1", c, led_out[0]);
            end
        end
    endtask

    task automatic test_pwm_duty();
        int hi;
        int exp_hi;
        exp_hi = GAMMA ? (128 * 128) / PERIOD : 128;
        @(negedge pl_clk);
        slow_rstn = 1'b1;
        slow_in   = 8'h01;
        repeat (2060) @(negedge pl_clk);
        slow_in = 8'h00;
        repeat (40) @(negedge pl_clk);
        n_cmp++;
        if (u_slow.level[0] !== 8'd128) begin
            n_bad++;
            $display("FAIL pwm_hold_level got %0d exp 128", u_slow.level[0]);
        end
        hi = 0;
        for (int c = 0; c < PERIOD; c++) begin
            @(negedge pl_clk);
            if (slow_out[0] === 1'b1) hi++;
        end
        n_cmp++;
        if (hi != exp_hi) begin
            n_bad++;
            $display("FAIL pwm_duty_count got %0d high cycles exp %0d", hi, exp_hi);
        end
    endtask

    task automatic test_reversal();
        int seen[$];
        int want[6];
        int prev;
        bit hit;
        want = '{64, 128, 192, 128, 64, 0};
        prev = 0;
        hit = 1'b0;
        led_in = 8'h80;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL rev_up_cycle t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
            if (int'(dut.level[7]) != prev) begin
                prev = int'(dut.level[7]);
                seen.push_back(prev);
            end
            if (prev == 192) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL rev_reach_192 got level %0d exp 192 within 40 cycles", prev);
        end
        led_in = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL rev_dn_cycle t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
            if (int'(dut.level[7]) != prev) begin
                prev = int'(dut.level[7]);
                seen.push_back(prev);
            end
        end
        n_cmp++;
        if (seen.size() != 6) begin
            n_bad++;
            $display("FAIL rev_step_count got %0d exp 6", seen.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (seen[k] != want[k]) begin
                    n_bad++;
                    $display("FAIL rev_step%0d got %0d exp %0d", k, seen[k], want[k]);
                end
            end
        end
        n_cmp++;
        if (settled !== 1'b1) begin
            n_bad++;
            $display("FAIL rev_settled got %b exp 1", settled);
        end
    endtask

    task automatic test_simultaneous();
        int guard;
        guard = 0;
        while (m_cyc % FD != 1 && guard < 8) begin
            @(negedge pl_clk);
            guard++;
        end
        n_cmp++;
        if (m_cyc % FD != 1) begin
            n_bad++;
            $display("FAIL sim_align got phase %0d exp 1", m_cyc % FD);
        end
        led_in = 8'h08;
        for (int c = 0; c < 3; c++) begin
            @(negedge pl_clk);
            led_in = 8'h00;
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL sim_cycle t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
        end
        n_cmp++;
        if (dut.level[3] !== 8'(ST)) begin
            n_bad++;
            $display("FAIL sim_pulse_tick got level %0d exp %0d", dut.level[3], ST);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL sim_decay t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
        end
        n_cmp++;
        if (dut.level[3] !== 8'd0) begin
            n_bad++;
            $display("FAIL sim_decay_zero got %0d exp 0", dut.level[3]);
        end
    endtask

    task automatic test_lockstep();
        led_in = 8'hFF;
        for (int c = 0; c < 30; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL lock_cycle t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
            n_cmp++;
            if (obs_lvl !== {8{obs_lvl[7:0]}}) begin
                n_bad++;
                $display("FAIL lock_equal t=%0t got lvl=%h exp all bytes equal", $time, obs_lvl);
            end
        end
        n_cmp++;
        if (led_out !== 8'hFF || settled !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_final got out=%h settled=%b exp out=ff settled=1", led_out, settled);
        end
    endtask

    task automatic test_reset_mid_ramp();
        bit hit;
        led_in = 8'h00;
        for (int c = 0; c < 30; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL rmr_fall t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
        end
        led_in = 8'h20;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL rmr_rise t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
            if (dut.level[5] === 8'd128) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL rmr_reach_128 got level %0d exp 128 within 40 cycles", dut.level[5]);
        end
        #2 pl_resetn = 1'b0;
        #1;
        n_cmp++;
        if (dut.level[5] !== 8'd0 || led_out !== 8'h00 || settled !== 1'b1) begin
            n_bad++;
            $display("FAIL rmr_async got lvl5=%0d out=%h settled=%b exp lvl5=0 out=00 settled=1",
                     dut.level[5], led_out, settled);
        end
        @(negedge pl_clk);
        pl_resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge pl_clk);
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL rmr_restart t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
            if (c == 2 || c == 3) begin
                n_cmp++;
                if (int'(dut.level[5]) != ((c == 3) ? ST : 0)) begin
                    n_bad++;
                    $display("FAIL rmr_phase0 cyc=%0d got %0d exp %0d",
                             c, dut.level[5], (c == 3) ? ST : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 11) == 0) led_in = 8'($urandom);
            @(negedge pl_clk);
            n_cmp++;
            if ({settled, led_out, obs_lvl} !== {m_set, m_out, exp_lvl}) begin
                n_bad++;
                $display("FAIL rand_cycle t=%0t got s=%b out=%h lvl=%h exp s=%b out=%h lvl=%h",
                         $time, settled, led_out, obs_lvl, m_set, m_out, exp_lvl);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp_up();
        test_pwm_duty();
        test_reversal();
        test_simultaneous();
        test_lockstep();
        test_reset_mid_ramp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Output stage between the LED pattern sources and the eight general-purpose LED pins.
- Takes the 8-bit LED pattern (shift stage on bits [3:0], count stage on bits [7:4]) and synchronises it into pl_clk.
- Each LED ramps its brightness up or down toward its target; it does not switch on or off instantly.
- Brightness is produced by a shared free-running PWM counter. The result is registered LED drive outputs plus a settled status flag.

Parameters:
- NUM_LED, 8, number of LED channels.
- PWM_BITS, 8, width of the PWM counter and of each brightness level; MAX = 2^PWM_BITS-1.
- FADE_DIV, 390625, pl_clk cycles per fade tick; must be >= 2.
- STEP, 1, brightness change per fade tick; range 1..MAX.

Ports:
- pl_clk  input  1  clock.
- pl_resetn  input  1  reset, asynchronous, active-low.
- led_in  input  NUM_LED  requested LED pattern; may be asynchronous to pl_clk.
- led_out  output  NUM_LED  PWM LED drive, registered.
- settled  output  1  high when every channel's level equals its target extreme.

Behaviour:
- Reset (asynchronous assert, synchronous release via pl_clk):
  - Synchroniser flops = 0, all levels = 0, PWM counter = 0, prescaler = 0.
  - led_out = 0, settled = 1.
- Input synchroniser:
  - Two flops per bit.
  - target[i] equals led_in[i] two rising edges after led_in changes, provided setup is met.
- Prescaler:
  - Counts 0..FADE_DIV-1 and wraps to 0.
  - tick is a one-cycle pulse in the cycle the count equals FADE_DIV-1.
  - Period is exactly FADE_DIV cycles.
- Level update (per channel, only on tick):
  - target=1 and level<MAX: level <= min(level+STEP, MAX). Saturate; never wrap.
  - target=0 and level>0: level <= max(level-STEP, 0). Saturate; never underflow.
  - Otherwise level holds.
  - A target change mid-ramp reverses direction at the next tick from the current level. There is no restart.
  - Width rule: compute in PWM_BITS+1 bits before saturating.
- PWM counter:
  - Increments every cycle, 0..MAX, wraps MAX->0.
  - Runs independently of tick.
- Duty mapping:
  - duty[i] = level[i].
  - See the optional feature for the gamma mapping.
- Output, registered, one cycle after the compare:
  - led_out[i] <= 1 if duty[i]==MAX.
  - Otherwise led_out[i] <= (duty[i] > pwm_cnt).
  - Result: level 0 is always off; level MAX is always on; level k is on k of every 2^PWM_BITS cycles.
- settled (registered):
  - settled = AND over i of (level[i] == (target[i] ? MAX : 0)).
  - It drops the cycle after any target mismatch is seen.
- Simultaneous events:
  - A tick in the same cycle as a target change uses the new target. This is the target register value in that cycle.
- Reset mid-ramp: all levels return to 0 immediately and led_out = 0.
- Latency from a led_in step to the first level change:
  - 2 cycles of sync, plus the wait to the next tick (up to FADE_DIV cycles).
  - The level then takes effect on led_out within 2^PWM_BITS+1 cycles.
- Full-ramp time: ceil(MAX/STEP) ticks.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined:
  - duty[i] = (level[i]*level[i]) >> PWM_BITS. The product is 2*PWM_BITS wide.
  - Exception: level==MAX forces duty=MAX.
  - Duty is registered, which adds one cycle of pipeline latency to led_out.
  - Gives a perceptually linear fade.
- Undefined: duty[i] = level[i] with no multiplier and no extra pipeline stage.
- settled and level behaviour are identical in both builds.

Test Plan:
- Bench parameters FADE_DIV=4, STEP=64, PWM_BITS=8.
- Reset check: assert pl_resetn=0 mid-clock -> immediately led_out=0, settled=1, all levels 0. Hold led_in=0 for 1000 cycles after release -> led_out stays 0.
- Ramp up: led_in 0x00 -> 0x01 -> settled falls. level[0] steps 0,64,128,192,255 on successive ticks (saturated at 255, not 256). settled rises after the 4th tick; led_out[0] is then constant 1.
- PWM duty: hold level[0]=128 (led_in=0x01, then 0x00 after 2 ticks) -> measured over 256 cycles before the next tick, led_out[0] high 128 cycles (non-gamma). With LED_FADE_GAMMA_EN defined, high 64 cycles.
- Reversal mid-ramp: led_in=0x80 for 3 ticks (level 192), then led_in=0x00 -> level 128, 64, 0. No wrap below 0; settled returns to 1.
- Synchroniser/simultaneity: toggle led_in[3] so target changes on a tick cycle -> that tick uses the new target. A led_in pulse of 1 cycle that meets setup is captured; led_in=0xFF ramps all 8 channels in lockstep.
- Reset mid-ramp: pl_resetn=0 while level[5]=128 -> level[5]=0 and led_out=0 asynchronously. After release, the ramp restarts from 0 at a prescaler phase of 0.
